// File: rtl/xor_stream_cipher.sv
// Word XOR cipher with static-key and LFSR-keystream modes. One-entry output
// register with valid/ready on both sides and a word counter.
module xor_stream_cipher #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [WIDTH-1:0] key_in,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic [CNT_W-1:0] word_cnt
);

  localparam logic [WIDTH-1:0] KS_ONE = WIDTH'(1);

  logic [WIDTH-1:0] key_q, key_d;
  logic [WIDTH-1:0] ks_q, ks_d;
  logic [WIDTH-1:0] out_word_q, out_word_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // in_valid never reaches in_ready; only the register and out_ready do.
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign word_cnt  = cnt_q;

  always_comb begin
    // NOTE: every *_d gets a hold default first so no path leaves it unassigned (no latches).
    key_d       = key_q;
    ks_d        = ks_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;

    if (accept) begin
      out_word_d  = in_word ^ (mode ? ks_q : key_q);
      out_valid_d = 1'b1;
      cnt_d       = cnt_q + CNT_W'(1);
      if (mode) ks_d = {ks_q[WIDTH-2:0], ^(ks_q & TAPS)};
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Key reload wins over the keystream advance and the count of a concurrent word;
    // an all-zero seed would lock the LFSR, so it is replaced by 1.
    if (key_load) begin
      key_d = key_in;
      ks_d  = (key_in == '0) ? KS_ONE : key_in;
      cnt_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q       <= '0;
      ks_q        <= KS_ONE;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      key_q       <= key_d;
      ks_q        <= ks_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Directed bench for xor_stream_cipher: static, rolling, round trip,
// backpressure, zero seed, key_load collision and mid-stream reset.
module tb_xor_stream_cipher;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_load;
  logic [3:0]  key_in;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_word;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_word;
  logic [15:0] word_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] ct [3];

  xor_stream_cipher dut (
    .clk      (clk),
    .rst      (rst),
    .key_load (key_load),
    .key_in   (key_in),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word (out_word),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [3:0] k);
    key_load = 1'b1;
    key_in   = k;
    tick();
    key_load = 1'b0;
  endtask

  // Present one word with out_ready high and sample the result one edge later.
  task automatic send(input logic [3:0] w, input logic m);
    in_valid = 1'b1;
    in_word  = w;
    mode     = m;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; key_load = 1'b0; key_in = '0; mode = 1'b0;
    in_valid = 1'b0; in_word = '0; out_ready = 1'b1;
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_word",  32'(out_word),  32'd0);
    check("rst_word_cnt",  32'(word_cnt),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    rst = 1'b0;
    tick();

    // Static: 0110 ^ 1010 = 1100
    load_key(4'b1010);
    check("keyload_cnt", 32'(word_cnt), 32'd0);
    send(4'b0110, 1'b0);
    check("static_valid", 32'(out_valid), 32'd1);
    check("static_word",  32'(out_word),  32'b1100);
    check("static_cnt",   32'(word_cnt),  32'd1);
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_hold",  32'(out_word),  32'b1100);

    // Rolling, back-to-back: 1010, 0101, 1011, 0111
    load_key(4'b1010);
    in_valid = 1'b1; in_word = 4'b0000; mode = 1'b1;
    tick(); check("roll0", 32'(out_word), 32'b1010);
    tick(); check("roll1", 32'(out_word), 32'b0101);
    tick(); check("roll2", 32'(out_word), 32'b1011);
    tick(); check("roll3", 32'(out_word), 32'b0111);
    in_valid = 1'b0;
    check("roll_cnt", 32'(word_cnt), 32'd4);
    tick();

    // Round trip: 0011,1100,1111 -> 1001,1001,0100 -> back
    load_key(4'b1010);
    send(4'b0011, 1'b1); ct[0] = out_word; check("enc0", 32'(out_word), 32'b1001);
    send(4'b1100, 1'b1); ct[1] = out_word; check("enc1", 32'(out_word), 32'b1001);
    send(4'b1111, 1'b1); ct[2] = out_word; check("enc2", 32'(out_word), 32'b0100);
    load_key(4'b1010);
    send(ct[0], 1'b1); check("dec0", 32'(out_word), 32'b0011);
    send(ct[1], 1'b1); check("dec1", 32'(out_word), 32'b1100);
    send(ct[2], 1'b1); check("dec2", 32'(out_word), 32'b1111);
    tick();

    // Backpressure: stall 3 cycles with a word waiting, then release
    load_key(4'b1010);
    in_valid = 1'b1; in_word = 4'b0000; mode = 1'b1;
    tick();
    check("bp_first", 32'(out_word), 32'b1010);
    out_ready = 1'b0;
    #1;
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_word",  32'(out_word),  32'b1010);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ready", 32'(in_ready),  32'd0);
      check("bp_hold_cnt",   32'(word_cnt),  32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_comb", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_next", 32'(out_word), 32'b0101);
    check("bp_cnt",  32'(word_cnt), 32'd2);
    tick();

    // Zero seed: ks = 1, key_reg = 0
    load_key(4'b0000);
    send(4'b0000, 1'b1); check("zero_roll",   32'(out_word), 32'b0001);
    send(4'b1001, 1'b0); check("zero_static", 32'(out_word), 32'b1001);
    tick();

    // key_load collides with a rolling accept
    load_key(4'b1010);
    key_load = 1'b1; key_in = 4'b0110;
    in_valid = 1'b1; in_word = 4'b0000; mode = 1'b1;
    tick();
    key_load = 1'b0; in_valid = 1'b0;
    check("coll_word", 32'(out_word), 32'b1010);
    check("coll_cnt",  32'(word_cnt), 32'd0);
    send(4'b0000, 1'b1);
    check("coll_next", 32'(out_word), 32'b0110);
    check("coll_next_cnt", 32'(word_cnt), 32'd1);

    // Mid-stream async reset with an output pending under backpressure
    out_ready = 1'b0;
    send(4'b0011, 1'b1);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_cnt",   32'(word_cnt),  32'd0);
    check("async_rst_ready", 32'(in_ready),  32'd1);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    tick();
    send(4'b0000, 1'b1);
    check("post_rst_ks_one", 32'(out_word), 32'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
